// File: rtl/instr_mem_pkg.sv
// Shared types and default widths for the loadable instruction memory.
package instr_mem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 30;

endpackage

// File: rtl/mod_instr_mem_array.sv
// Instruction storage: one write port, one synchronous read port, no reset.
module mod_instr_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read data only moves on re, so a stalled response keeps its word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mod_instruction_mem_ram.sv
// Loadable instruction memory: sequential load port, then valid/ready fetches
// with one registered read stage and an end-of-program flag.
module mod_instruction_mem_ram
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 64,
    localparam int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              reload,
    output logic              ld_err,
    output logic              loaded,
    output logic [LEN_W-1:0]  prog_len,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] address,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] instruction,
    output logic              mem_end
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CMP_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

    // Handshake: a request transfers on a cycle where req_valid & req_ready;
    // a response transfers where rsp_valid & rsp_ready, and until then the
    // response (instruction, mem_end) is held stable.

    state_t            state;
    logic [LEN_W-1:0]  wptr;
    logic              hit_q;
    logic              accept;
    logic              in_range;
    logic              wr_en;
    logic [LEN_W-1:0]  len_next;
    logic [DATA_W-1:0] rd_data;

    assign loaded    = (state == ST_RUN);
    assign req_ready = (state == ST_RUN) & ~reload & (~rsp_valid | rsp_ready);
    assign accept    = req_valid & req_ready;
    assign in_range  = CMP_W'(address) < CMP_W'(prog_len);
    assign wr_en     = (state == ST_LOAD) & ~reload & ld_en & (wptr < LEN_W'(DEPTH));
    assign len_next  = (wptr == LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : wptr + LEN_W'(1);

    // Out-of-range fetches never read the array; the output is forced to zero.
    assign instruction = hit_q ? rd_data : '0;

    mod_instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (IDX_W'(wptr)),
        .wdata (ld_data),
        .re    (accept & in_range),
        .raddr (IDX_W'(address)),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            wptr      <= '0;
            prog_len  <= '0;
            ld_err    <= 1'b0;
            rsp_valid <= 1'b0;
            mem_end   <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (reload) begin
                        wptr   <= '0;
                        ld_err <= 1'b0;
                    end else if (ld_en) begin
                        if (wr_en) begin
                            wptr <= wptr + LEN_W'(1);
                        end else begin
                            ld_err <= 1'b1;
                        end
                        if (ld_last) begin
                            prog_len <= len_next;
                            wptr     <= '0;
                            state    <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        state     <= ST_LOAD;
                        prog_len  <= '0;
                        wptr      <= '0;
                        ld_err    <= 1'b0;
                        rsp_valid <= 1'b0;
                    end else if (accept) begin
                        rsp_valid <= 1'b1;
                        mem_end   <= ~in_range;
                        hit_q     <= in_range;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_instruction_mem_ram.sv
// Directed bench for mod_instruction_mem_ram with a 4-word memory.
module tb_mod_instruction_mem_ram;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 30;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_en = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              reload = 1'b0;
  logic              ld_err;
  logic              loaded;
  logic [LEN_W-1:0]  prog_len;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] address = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] instruction;
  logic              mem_end;

  int checks = 0;
  int errors = 0;

  mod_instruction_mem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .ld_en       (ld_en),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .reload      (reload),
    .ld_err      (ld_err),
    .loaded      (loaded),
    .prog_len    (prog_len),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .address     (address),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .instruction (instruction),
    .mem_end     (mem_end)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DATA_W-1:0] d, input logic last);
    ld_en   = 1'b1;
    ld_data = d;
    ld_last = last;
    step();
    ld_en   = 1'b0;
    ld_last = 1'b0;
  endtask

  task automatic test_reset();
    // outputs while reset is held, with a fetch already being requested
    req_valid = 1'b1;
    address   = '0;
    rsp_ready = 1'b1;
    #2;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded: got %b want 0", loaded); end
    checks++; if (prog_len !== '0) begin errors++; $display("FAIL rst_prog_len: got %0d want 0", prog_len); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL rst_ld_err: got %b want 0", ld_err); end
    checks++; if (instruction !== '0) begin errors++; $display("FAIL rst_instruction: got %h want 0", instruction); end
    checks++; if (mem_end !== 1'b0) begin errors++; $display("FAIL rst_mem_end: got %b want 0", mem_end); end
    @(negedge clk);
    rst = 1'b0;
    // fetch in LOAD state is never accepted
    for (int i = 0; i < 2; i++) begin
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_req_ready[%0d]: got %b want 0", i, req_ready); end
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL load_rsp_valid[%0d]: got %b want 0", i, rsp_valid); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_fetch();
    logic [DATA_W-1:0] exp_i [4];
    logic              exp_e [4];
    exp_i = '{32'h0400_0001, 32'h0401_0002, 32'h0402_0003, 32'h0};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b1};
    load_word(32'h0400_0001, 1'b0);
    load_word(32'h0401_0002, 1'b0);
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL fetch_loaded_early: got %b want 0", loaded); end
    load_word(32'h0402_0003, 1'b1);
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL fetch_loaded: got %b want 1", loaded); end
    checks++; if (prog_len !== 3'd3) begin errors++; $display("FAIL fetch_prog_len: got %0d want 3", prog_len); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL fetch_ld_err: got %b want 0", ld_err); end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = ADDR_W'(i);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fetch_req_ready[%0d]: got %b want 1", i, req_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL fetch_rsp_valid[%0d]: got %b want 1", i, rsp_valid); end
      checks++; if (instruction !== exp_i[i]) begin errors++; $display("FAIL fetch_instr[%0d]: got %h want %h", i, instruction, exp_i[i]); end
      checks++; if (mem_end !== exp_e[i]) begin errors++; $display("FAIL fetch_mem_end[%0d]: got %b want %b", i, mem_end, exp_e[i]); end
    end
    req_valid = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    address   = 30'd1;
    step();
    address   = 30'd2;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b want 1", i, rsp_valid); end
      checks++; if (instruction !== 32'h0401_0002) begin errors++; $display("FAIL bp_instr[%0d]: got %h want 04010002", i, instruction); end
      checks++; if (mem_end !== 1'b0) begin errors++; $display("FAIL bp_mem_end[%0d]: got %b want 0", i, mem_end); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    checks++; if (instruction !== 32'h0402_0003) begin errors++; $display("FAIL bp_next_instr: got %h want 04020003", instruction); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b want 1", rsp_valid); end
    step();
  endtask

  task automatic test_reload();
    logic [DATA_W-1:0] exp_i [3];
    logic              exp_e [3];
    exp_i = '{32'hAAAA_0001, 32'hBBBB_0002, 32'h0};
    exp_e = '{1'b0, 1'b0, 1'b1};
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    address   = 30'd0;
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rl_pending: got %b want 1", rsp_valid); end
    rsp_ready = 1'b1;
    reload    = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rl_req_ready: got %b want 0", req_ready); end
    step();
    reload    = 1'b0;
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rl_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL rl_loaded: got %b want 0", loaded); end
    checks++; if (prog_len !== '0) begin errors++; $display("FAIL rl_prog_len: got %0d want 0", prog_len); end
    load_word(32'hAAAA_0001, 1'b0);
    load_word(32'hBBBB_0002, 1'b1);
    checks++; if (prog_len !== 3'd2) begin errors++; $display("FAIL rl_prog_len2: got %0d want 2", prog_len); end
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = ADDR_W'(i);
      step();
      checks++; if (instruction !== exp_i[i]) begin errors++; $display("FAIL rl_instr[%0d]: got %h want %h", i, instruction, exp_i[i]); end
      checks++; if (mem_end !== exp_e[i]) begin errors++; $display("FAIL rl_mem_end[%0d]: got %b want %b", i, mem_end, exp_e[i]); end
    end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] exp_i [3];
    logic              exp_e [3];
    addrs = '{30'd4, 30'h3FFF_FFFF, 30'd3};
    exp_i = '{32'h0, 32'h0, 32'h1100_0003};
    exp_e = '{1'b1, 1'b1, 1'b0};
    reload = 1'b1;
    step();
    reload = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_word(32'h1100_0000 + DATA_W'(i), (i == 5));
      if (i == 3) begin
        checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %b want 0", ld_err); end
      end
    end
    checks++; if (ld_err !== 1'b1) begin errors++; $display("FAIL ovf_ld_err: got %b want 1", ld_err); end
    checks++; if (prog_len !== 3'd4) begin errors++; $display("FAIL ovf_prog_len: got %0d want 4", prog_len); end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL ovf_loaded: got %b want 1", loaded); end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = addrs[i];
      step();
      checks++; if (instruction !== exp_i[i]) begin errors++; $display("FAIL ovf_instr[%0d]: got %h want %h", i, instruction, exp_i[i]); end
      checks++; if (mem_end !== exp_e[i]) begin errors++; $display("FAIL ovf_mem_end[%0d]: got %b want %b", i, mem_end, exp_e[i]); end
    end
    // leave the last response pending for the mid-fetch reset
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (instruction !== '0) begin errors++; $display("FAIL ar_instr: got %h want 0", instruction); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL ar_ld_err: got %b want 0", ld_err); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL ar_loaded: got %b want 0", loaded); end
    checks++; if (prog_len !== '0) begin errors++; $display("FAIL ar_prog_len: got %0d want 0", prog_len); end
    @(negedge clk);
    rst = 1'b0;
    step();
    // mid-load reset: the write pointer must restart from zero
    load_word(32'hDEAD_0001, 1'b0);
    load_word(32'hDEAD_0002, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL ar_load_loaded: got %b want 0", loaded); end
    @(negedge clk);
    rst = 1'b0;
    step();
    load_word(32'hCAFE_0000, 1'b1);
    checks++; if (prog_len !== 3'd1) begin errors++; $display("FAIL ar_prog_len1: got %0d want 1", prog_len); end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    address   = 30'd0;
    step();
    checks++; if (instruction !== 32'hCAFE_0000) begin errors++; $display("FAIL ar_instr0: got %h want cafe0000", instruction); end
    address   = 30'd1;
    step();
    checks++; if (mem_end !== 1'b1) begin errors++; $display("FAIL ar_mem_end1: got %b want 1", mem_end); end
    req_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_reload();
    test_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_instruction_mem_ram.md
Name: mod_instruction_mem_ram

Overview:
Parametrised, loadable instruction memory that supersedes the fixed combinational instruction ROM. A sequential load port fills it with a program and sets the program length at run time. Fetches then use a valid/ready request/response handshake with one registered read stage. Sits between the PC/fetch stage and the decode stage; mem_end flags fetches past the loaded program.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 30, word-address width of fetch address
DEPTH, 64, number of instruction words stored (>=2)
LEN_W, $clog2(DEPTH+1), width of program-length counter (derived, localparam)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
ld_en  in  1  load strobe; writes ld_data at internal write pointer
ld_data  in  DATA_W  instruction word to load
ld_last  in  1  with ld_en: final word of program
reload  in  1  single-cycle pulse; return to LOAD state
ld_err  out  1  sticky: load attempted beyond DEPTH
loaded  out  1  high in RUN state (program valid)
prog_len  out  LEN_W  number of valid program words
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted when valid&ready
address  in  ADDR_W  word address of fetch
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
instruction  out  DATA_W  fetched word
mem_end  out  1  fetched address >= prog_len (registered with instruction)

Behaviour:
- Reset (async, immediate): state=LOAD, wptr=0, prog_len=0, ld_err=0, rsp_valid=0, instruction=0, mem_end=0, loaded=0. Array contents not reset.
- States: LOAD, RUN. LOAD->RUN on ld_en&ld_last. RUN->LOAD on reload. reload in LOAD: wptr=0, ld_err=0, stay LOAD.
- LOAD, ld_en=1, wptr<DEPTH: mem[wptr]<=ld_data, wptr<=wptr+1.
- LOAD, ld_en=1, wptr==DEPTH: write dropped, wptr held, ld_err<=1.
- ld_en&ld_last: prog_len<=min(wptr+1, DEPTH); wptr<=0; enter RUN. ld_last without ld_en ignored.
- ld_en ignored in RUN.
- req_ready = (state==RUN) & ~reload & (~rsp_valid | rsp_ready). Combinational, no dependence on req_valid.
- Accept (req_valid&req_ready): next cycle rsp_valid=1.
  - If {0,address} < prog_len (zero-extended to max(ADDR_W,LEN_W)): instruction=mem[address], mem_end=0.
  - Else: instruction=0, mem_end=1.
  - Latency: 1 cycle.
- Hold: rsp_valid&~rsp_ready keeps instruction and mem_end stable; no new request accepted.
- Drain: rsp_valid&rsp_ready with no new accept -> rsp_valid<=0. Accept the same cycle -> back-to-back responses, full throughput.
- reload in RUN: state<=LOAD, prog_len<=0, wptr<=0, ld_err<=0, rsp_valid<=0 (pending response dropped). reload takes priority over a same-cycle request, which is not accepted.
- Mid-operation reset: all state and outputs return to reset values immediately.

Decomposition:
- Package instr_mem_pkg: state enum (ST_LOAD, ST_RUN); default width constants DATA_W_DEF=32, ADDR_W_DEF=30.
- One sub-module: mod_instr_mem_array, single write port and single synchronous read port, parametrised on DATA_W/DEPTH, no reset. Controller/handshake logic lives in the top module.

Test Plan:
- Load 3 words 0x04000001, 0x04010002, 0x04020003 (last on 3rd) -> prog_len=3, loaded=1; fetch addr 0,1,2,3 back-to-back with rsp_ready=1 -> responses 1 cycle later in order: 3 words with mem_end=0, then instruction=0 with mem_end=1.
- Backpressure: rsp_ready=0 for 4 cycles after fetch of addr 1 -> rsp_valid high, instruction=0x04010002 stable, req_ready=0; release -> next request accepted same cycle.
- Overflow with DEPTH=4: 6 ld_en words, last on 6th -> ld_err=1, prog_len=4, addr 3 returns 4th word, addr 4 gives mem_end=1.
- Fetch in LOAD state (after reset, before ld_last) -> req_ready=0, rsp_valid stays 0.
- reload same cycle as req_valid with a response pending -> request not accepted, rsp_valid=0 next cycle, loaded=0, prog_len=0; reload 2 words -> prog_len=2, fetches correct.
- Assert rst mid-load and mid-fetch (async, between edges) -> all outputs 0 immediately; wptr restarts at 0 on next load.
